// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I-subset core.
// Sequences the shared ALU and datapath: decodes the latched instruction fields,
// drives the ALU operand selects and ALUControl, and gates PC/IR/memory/regfile writes.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   op         - instr[6:0] from IR
//   funct3     - instr[14:12]
//   funct7b5   - instr[30]
//   Zero       - ALU zero flag (resolves BEQ in the same cycle)
//   PCWrite    - PC load enable
//   AdrSrc     - memory address select: 0=PC, 1=ALUOut
//   MemWrite   - data memory write enable
//   IRWrite    - IR/OldPC load enable
//   RegWrite   - register file write enable
//   ResultSrc  - result select: 00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA    - operand A select: 00=PC, 01=OldPC, 10=rs1
//   ALUSrcB    - operand B select: 00=rs2, 01=imm, 10=constant 4
//   ALUControl - 000 add, 001 sub, 010 and, 011 or, 101 slt
//   Illegal    - one-cycle pulse when an unsupported opcode is decoded
//   state      - current state, for debug
module multicycle_controller #(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUControl,
   output logic               Illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecuteR,
      StExecuteI,
      StAluWb,
      StBeq,
      StJal
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   state_e     state_q, state_d;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;
   logic [2:0] alu_dec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // ALU decoder; only R-type with funct7b5 set selects sub (addi is never sub).
   always_comb begin
      alu_dec = 3'b000;
      unique case (alu_op)
         2'b00: alu_dec = 3'b000;
         2'b01: alu_dec = 3'b001;
         2'b10: begin
            unique case (funct3)
               3'b000:  alu_dec = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alu_dec = 3'b101;
               3'b110:  alu_dec = 3'b011;
               3'b111:  alu_dec = 3'b010;
               default: alu_dec = 3'b000;
            endcase
         end
         default: alu_dec = 3'b000;
      endcase
   end

   always_comb begin
      state_d   = StFetch;
      alu_op    = 2'b00;
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      Illegal   = 1'b0;

      unique case (state_q)
         StFetch: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pc_update = 1'b1;
            state_d   = StDecode;
         end
         StDecode: begin
            // Branch target is precomputed into ALUOut here.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            unique case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecuteR;
               OpIType:         state_d = StExecuteI;
               OpBranch:        state_d = StBeq;
               OpJal:           state_d = StJal;
               default: begin
                  state_d = StFetch;
                  Illegal = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            // op[5] distinguishes sw from lw.
            state_d = op[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            AdrSrc  = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            state_d  = StFetch;
         end
         StExecuteR: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
            state_d = StAluWb;
         end
         StExecuteI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
            state_d = StAluWb;
         end
         StAluWb: begin
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StBeq: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
            state_d = StFetch;
         end
         StJal: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = StAluWb;
         end
         default: state_d = StFetch;
      endcase

      ALUControl = alu_dec;
      PCWrite    = pc_update | (branch & Zero);

      // Mask every output while reset is held so no enable leaks on the next edge.
      if (!reset) begin
         PCWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         ResultSrc  = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ALUControl = 3'b000;
         Illegal    = 1'b0;
      end
   end

   assign state = reset ? state_q : StFetch;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the shared 32-bit ALU and the datapath in the multicycle RV32I-subset core.
- Decodes the latched instruction fields, drives the ALU operand muxes and ALUControl every cycle, and gates PC, IR, memory and register-file writes.
- Consumes the ALU Zero flag to resolve BEQ.
- Sits between the instruction register and the datapath muxes / ALU.

Parameters:
STATE_W, 4, width of the state register and of the state debug output.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU zero flag
PCWrite  output  1  PC load enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  IR/OldPC load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  operand A select: 00=PC, 01=OldPC, 10=rs1
ALUSrcB  output  2  operand B select: 00=rs2, 01=imm, 10=constant 4
ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
Illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
state  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - reset low forces state=FETCH asynchronously.
  - While reset is low, all outputs are 0 (ALUControl=000); combinational decode is masked.
  - The first rising edge after release is the FETCH cycle.
- Encoding: states 0..10 are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Per-state outputs. Any output not listed is 0; ALUOp is an internal signal.
  - FETCH: IRWrite=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch target into ALUOut).
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: SrcA=10, SrcB=00, ALUOp=10.
  - EXECUTEI: SrcA=10, SrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero). It is combinational in the same cycle, so Zero must be valid within the BEQ cycle.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - Any other op -> FETCH with Illegal=1 for that DECODE cycle only; no write enable asserts.
  - MEMADR: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - JAL -> ALUWB.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- ALU decode (combinational):
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000 (addi is never sub).
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - Others -> 000.
- Simultaneous events: BEQ with Zero=1 and an in-flight MemWrite cannot coincide (mutually exclusive states).
- Reset asserted mid-instruction aborts it immediately. Enables drop in the same cycle, with no partial write on the next edge.
- op/funct are sampled only in DECODE, MEMADR and EXECUTE*. The IR is stable in those states because IRWrite is 1 only in FETCH.

Test Plan:
- Reset then release with op=0110011, funct3=000, funct7b5=1 -> state 0,1,6,8,0; EXECUTER has ALUControl=001; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- lw (op=0000011) -> states 0,1,2,3,4; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB; 5 cycles total.
- sw (op=0100011) -> MemWrite=1 for exactly one cycle (MEMWRITE); RegWrite never asserts; 4 cycles.
- beq with Zero=1 -> PCWrite=1 in BEQ and ALUControl=001; repeat with Zero=0 -> PCWrite=0 in BEQ; both return to FETCH after 3 cycles.
- I-type with funct3=000, funct7b5=1 -> ALUControl=000 (add, not sub); funct3=111 -> 010; funct3=010 -> 101.
- op=1111111 -> Illegal=1 in the DECODE cycle then FETCH; separately, pull reset low during MEMWRITE -> MemWrite=0 immediately and state=0.
